// File: rtl/id_ex_stage_pkg.sv
// id_ex_stage_pkg: shared definitions for the ID/EX pipeline stage.
//   - default operand / register-index widths
//   - decode opcode constants (as produced by the upstream control unit)
//   - packed control-bit bundle and the bubble (no-op) control vector
package id_ex_stage_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int REG_AW_DEF = 4;

    localparam logic [3:0] OP_ALU  = 4'b0000;
    localparam logic [3:0] OP_ST   = 4'b0001;
    localparam logic [3:0] OP_ADDI = 4'b0011;
    localparam logic [3:0] OP_ALU2 = 4'b0111;

    typedef struct packed {
        logic alu_src;
        logic mr;
        logic mw;
        logic mreg;
        logic enrw;
    } ctrl_t;

    // All-zero control: no memory access, no register write.
    localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/id_ex_stage_if.sv
// id_ex_stage_if: bundle of ID-side inputs, EX-side outputs and the
// fetch/decode back-pressure signals of the ID/EX stage.
//   master modport: drives id_* and flush, observes ex_*, pc_write,
//                   ifid_write, stall, stall_cnt (decode side / bench)
//   slave modport : the id_ex_stage itself
interface id_ex_stage_if
    import id_ex_stage_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_AW = REG_AW_DEF,
    parameter int CNT_W  = 16
);
    logic              id_alu_src;
    logic              id_mr;
    logic              id_mw;
    logic              id_mreg;
    logic              id_enrw;
    logic              id_valid;
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic [REG_AW-1:0] id_rd;
    logic [DATA_W-1:0] id_rs_data;
    logic [DATA_W-1:0] id_rt_data;
    logic [DATA_W-1:0] id_imm;
    logic              flush;

    logic              ex_alu_src;
    logic              ex_mr;
    logic              ex_mw;
    logic              ex_mreg;
    logic              ex_enrw;
    logic              ex_valid;
    logic [REG_AW-1:0] ex_rs;
    logic [REG_AW-1:0] ex_rt;
    logic [REG_AW-1:0] ex_rd;
    logic [DATA_W-1:0] ex_rs_data;
    logic [DATA_W-1:0] ex_rt_data;
    logic [DATA_W-1:0] ex_imm;
    logic              pc_write;
    logic              ifid_write;
    logic              stall;
    logic [CNT_W-1:0]  stall_cnt;

    modport master (
        output id_alu_src, id_mr, id_mw, id_mreg, id_enrw, id_valid,
               id_rs, id_rt, id_rd, id_rs_data, id_rt_data, id_imm, flush,
        input  ex_alu_src, ex_mr, ex_mw, ex_mreg, ex_enrw, ex_valid,
               ex_rs, ex_rt, ex_rd, ex_rs_data, ex_rt_data, ex_imm,
               pc_write, ifid_write, stall, stall_cnt
    );

    modport slave (
        input  id_alu_src, id_mr, id_mw, id_mreg, id_enrw, id_valid,
               id_rs, id_rt, id_rd, id_rs_data, id_rt_data, id_imm, flush,
        output ex_alu_src, ex_mr, ex_mw, ex_mreg, ex_enrw, ex_valid,
               ex_rs, ex_rt, ex_rd, ex_rs_data, ex_rt_data, ex_imm,
               pc_write, ifid_write, stall, stall_cnt
    );

endinterface

// File: rtl/id_ex_stage_hazard_detect.sv
// id_ex_stage_hazard_detect: combinational load-use hazard detection.
// Ports:
//   i_rst                      synchronous reset (forces stall/write enables low)
//   i_flush                    branch redirect; suppresses the stall
//   i_ex_valid/i_ex_mr/i_ex_rd instruction currently in EX
//   i_id_valid/i_id_alu_src/i_id_mw/i_id_rs/i_id_rt  instruction in ID
//   o_stall                    hazard accepted this cycle
//   o_pc_write/o_ifid_write    fetch/decode advance enables
module id_ex_stage_hazard_detect
    import id_ex_stage_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic              i_rst,
    input  logic              i_flush,
    input  logic              i_ex_valid,
    input  logic              i_ex_mr,
    input  logic [REG_AW-1:0] i_ex_rd,
    input  logic              i_id_valid,
    input  logic              i_id_alu_src,
    input  logic              i_id_mw,
    input  logic [REG_AW-1:0] i_id_rs,
    input  logic [REG_AW-1:0] i_id_rt,
    output logic              o_stall,
    output logic              o_pc_write,
    output logic              o_ifid_write
);
    logic w_rt_used;
    logic w_hazard;

    // rt is a real source for register-register ops and for stores (store data).
    assign w_rt_used = ~i_id_alu_src | i_id_mw;

    assign w_hazard = i_ex_valid & i_ex_mr & i_id_valid &
                      ((i_ex_rd == i_id_rs) | (w_rt_used & (i_ex_rd == i_id_rt)));

    // A flush already discards the ID instruction, so no stall is needed.
    assign o_stall      = w_hazard & ~i_flush & ~i_rst;
    assign o_pc_write   = ~o_stall & ~i_rst;
    assign o_ifid_write = ~o_stall & ~i_rst;

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use stall generation.
// Ports:
//   clk, rst  rising-edge clock, synchronous active-high reset
//   bus       id_ex_stage_if.slave: decoded ID fields and flush in;
//             registered EX fields, pc_write/ifid_write/stall and the
//             saturating stall-cycle counter out
// Every non-reset edge loads the register; a flush or stall loads a bubble.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_AW = REG_AW_DEF,
    parameter int CNT_W  = 16
) (
    input  logic            clk,
    input  logic            rst,
    id_ex_stage_if.slave    bus
);
    ctrl_t             r_ctrl;
    logic              r_valid;
    logic [REG_AW-1:0] r_rs;
    logic [REG_AW-1:0] r_rt;
    logic [REG_AW-1:0] r_rd;
    logic [DATA_W-1:0] r_rs_data;
    logic [DATA_W-1:0] r_rt_data;
    logic [DATA_W-1:0] r_imm;
    logic [CNT_W-1:0]  r_stall_cnt;

    ctrl_t w_id_ctrl;
    logic  w_stall;
    logic  w_pc_write;
    logic  w_ifid_write;
    logic  w_bubble;

    id_ex_stage_hazard_detect #(
        .REG_AW (REG_AW)
    ) u_hazard_detect (
        .i_rst        (rst),
        .i_flush      (bus.flush),
        .i_ex_valid   (r_valid),
        .i_ex_mr      (r_ctrl.mr),
        .i_ex_rd      (r_rd),
        .i_id_valid   (bus.id_valid),
        .i_id_alu_src (bus.id_alu_src),
        .i_id_mw      (bus.id_mw),
        .i_id_rs      (bus.id_rs),
        .i_id_rt      (bus.id_rt),
        .o_stall      (w_stall),
        .o_pc_write   (w_pc_write),
        .o_ifid_write (w_ifid_write)
    );

    // An empty decode slot still carries its fields, but must never write
    // memory or the register file.
    always_comb begin
        w_id_ctrl = '{alu_src: bus.id_alu_src, mr: bus.id_mr, mw: bus.id_mw,
                      mreg: bus.id_mreg, enrw: bus.id_enrw};
        if (!bus.id_valid) begin
            w_id_ctrl.mw   = 1'b0;
            w_id_ctrl.enrw = 1'b0;
        end
    end

    assign w_bubble = bus.flush | w_stall;

    always_ff @(posedge clk) begin
        if (rst || w_bubble) begin
            r_valid   <= 1'b0;
            r_ctrl    <= CTRL_BUBBLE;
            r_rs      <= '0;
            r_rt      <= '0;
            r_rd      <= '0;
            r_rs_data <= '0;
            r_rt_data <= '0;
            r_imm     <= '0;
        end else begin
            r_valid   <= bus.id_valid;
            r_ctrl    <= w_id_ctrl;
            r_rs      <= bus.id_rs;
            r_rt      <= bus.id_rt;
            r_rd      <= bus.id_rd;
            r_rs_data <= bus.id_rs_data;
            r_rt_data <= bus.id_rt_data;
            r_imm     <= bus.id_imm;
        end
    end

    // Saturating: holds at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign bus.ex_alu_src = r_ctrl.alu_src;
    assign bus.ex_mr      = r_ctrl.mr;
    assign bus.ex_mw      = r_ctrl.mw;
    assign bus.ex_mreg    = r_ctrl.mreg;
    assign bus.ex_enrw    = r_ctrl.enrw;
    assign bus.ex_valid   = r_valid;
    assign bus.ex_rs      = r_rs;
    assign bus.ex_rt      = r_rt;
    assign bus.ex_rd      = r_rd;
    assign bus.ex_rs_data = r_rs_data;
    assign bus.ex_rt_data = r_rt_data;
    assign bus.ex_imm     = r_imm;
    assign bus.pc_write   = w_pc_write;
    assign bus.ifid_write = w_ifid_write;
    assign bus.stall      = w_stall;
    assign bus.stall_cnt  = r_stall_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed table-driven bench for id_ex_stage, plus
// hand-written reset, reset-during-hazard and counter-saturation sequences
// (the saturation case uses a second instance with a 2-bit counter).
module tb_id_ex_stage;

    logic clk;
    logic rst;
    logic rst2;

    id_ex_stage_if #(.DATA_W(16), .REG_AW(4), .CNT_W(16)) u_if ();
    id_ex_stage_if #(.DATA_W(16), .REG_AW(4), .CNT_W(2))  u_if2 ();

    id_ex_stage #(.DATA_W(16), .REG_AW(4), .CNT_W(16)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if)
    );

    id_ex_stage #(.DATA_W(16), .REG_AW(4), .CNT_W(2)) u_dut2 (
        .clk (clk),
        .rst (rst2),
        .bus (u_if2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // ctrl / e_ctrl packing: {alu_src, mr, mw, mreg, enrw}
    typedef struct {
        logic        v;
        logic [4:0]  ctrl;
        logic [3:0]  rs, rt, rd;
        logic [15:0] rsd, rtd, imm;
        logic        fl;
        logic        e_stall;
        logic        e_valid;
        logic [4:0]  e_ctrl;
        logic [3:0]  e_rs, e_rt, e_rd;
        logic [15:0] e_rsd, e_rtd, e_imm;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string nm, input int idx, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s [%0d]: got %h expected %h", nm, idx, got, exp);
    endtask

    task automatic drive(input vec_t v);
        {u_if.id_alu_src, u_if.id_mr, u_if.id_mw, u_if.id_mreg, u_if.id_enrw} = v.ctrl;
        u_if.id_valid   = v.v;
        u_if.id_rs      = v.rs;
        u_if.id_rt      = v.rt;
        u_if.id_rd      = v.rd;
        u_if.id_rs_data = v.rsd;
        u_if.id_rt_data = v.rtd;
        u_if.id_imm     = v.imm;
        u_if.flush      = v.fl;
    endtask

    task automatic chk_comb(input string tag, input int idx, input logic e_stall, input logic e_pcw);
        chk({tag, ".stall"}, idx, 32'(u_if.stall), 32'(e_stall));
        chk({tag, ".pc_write"}, idx, 32'(u_if.pc_write), 32'(e_pcw));
        chk({tag, ".ifid_write"}, idx, 32'(u_if.ifid_write), 32'(e_pcw));
    endtask

    task automatic chk_regs(input string tag, input int idx, input vec_t v);
        chk({tag, ".ex_valid"}, idx, 32'(u_if.ex_valid), 32'(v.e_valid));
        chk({tag, ".ex_ctrl"}, idx,
            32'({u_if.ex_alu_src, u_if.ex_mr, u_if.ex_mw, u_if.ex_mreg, u_if.ex_enrw}), 32'(v.e_ctrl));
        chk({tag, ".ex_rs"}, idx, 32'(u_if.ex_rs), 32'(v.e_rs));
        chk({tag, ".ex_rt"}, idx, 32'(u_if.ex_rt), 32'(v.e_rt));
        chk({tag, ".ex_rd"}, idx, 32'(u_if.ex_rd), 32'(v.e_rd));
        chk({tag, ".ex_rs_data"}, idx, 32'(u_if.ex_rs_data), 32'(v.e_rsd));
        chk({tag, ".ex_rt_data"}, idx, 32'(u_if.ex_rt_data), 32'(v.e_rtd));
        chk({tag, ".ex_imm"}, idx, 32'(u_if.ex_imm), 32'(v.e_imm));
        chk({tag, ".stall_cnt"}, idx, 32'(u_if.stall_cnt), 32'(v.e_cnt));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t rv, m;
        logic [1:0] sat_exp[5];

        //          v     ctrl      rs     rt     rd     rsd       rtd       imm       fl    stall ev    ectrl     ers    ert    erd    ersd      ertd      eimm      ecnt
        vecs[0]  = '{1'b1, 5'b00001, 4'd2,  4'd3,  4'd4,  16'h1234, 16'h00AB, 16'h0005, 1'b0, 1'b0, 1'b1, 5'b00001, 4'd2,  4'd3,  4'd4,  16'h1234, 16'h00AB, 16'h0005, 16'd0};
        vecs[1]  = '{1'b1, 5'b11011, 4'd1,  4'd0,  4'd5,  16'h1111, 16'h2222, 16'h0010, 1'b0, 1'b0, 1'b1, 5'b11011, 4'd1,  4'd0,  4'd5,  16'h1111, 16'h2222, 16'h0010, 16'd0};
        vecs[2]  = '{1'b1, 5'b00001, 4'd5,  4'd7,  4'd8,  16'hAAAA, 16'hBBBB, 16'h0000, 1'b0, 1'b1, 1'b0, 5'b00000, 4'd0,  4'd0,  4'd0,  16'h0000, 16'h0000, 16'h0000, 16'd1};
        vecs[3]  = '{1'b1, 5'b00001, 4'd5,  4'd7,  4'd8,  16'hAAAA, 16'hBBBB, 16'h0000, 1'b0, 1'b0, 1'b1, 5'b00001, 4'd5,  4'd7,  4'd8,  16'hAAAA, 16'hBBBB, 16'h0000, 16'd1};
        vecs[4]  = '{1'b1, 5'b11011, 4'd0,  4'd0,  4'd6,  16'h0006, 16'h0000, 16'h0020, 1'b0, 1'b0, 1'b1, 5'b11011, 4'd0,  4'd0,  4'd6,  16'h0006, 16'h0000, 16'h0020, 16'd1};
        vecs[5]  = '{1'b1, 5'b10001, 4'd1,  4'd6,  4'd9,  16'h0101, 16'h0606, 16'h0003, 1'b0, 1'b0, 1'b1, 5'b10001, 4'd1,  4'd6,  4'd9,  16'h0101, 16'h0606, 16'h0003, 16'd1};
        vecs[6]  = '{1'b1, 5'b11011, 4'd2,  4'd0,  4'd6,  16'h0000, 16'h0000, 16'h0030, 1'b0, 1'b0, 1'b1, 5'b11011, 4'd2,  4'd0,  4'd6,  16'h0000, 16'h0000, 16'h0030, 16'd1};
        vecs[7]  = '{1'b1, 5'b10100, 4'd1,  4'd6,  4'd0,  16'h0101, 16'h0606, 16'h0004, 1'b0, 1'b1, 1'b0, 5'b00000, 4'd0,  4'd0,  4'd0,  16'h0000, 16'h0000, 16'h0000, 16'd2};
        vecs[8]  = '{1'b1, 5'b10100, 4'd1,  4'd6,  4'd0,  16'h0101, 16'h0606, 16'h0004, 1'b0, 1'b0, 1'b1, 5'b10100, 4'd1,  4'd6,  4'd0,  16'h0101, 16'h0606, 16'h0004, 16'd2};
        vecs[9]  = '{1'b1, 5'b11011, 4'd0,  4'd0,  4'd3,  16'h0000, 16'h0000, 16'h0040, 1'b0, 1'b0, 1'b1, 5'b11011, 4'd0,  4'd0,  4'd3,  16'h0000, 16'h0000, 16'h0040, 16'd2};
        vecs[10] = '{1'b1, 5'b00001, 4'd3,  4'd4,  4'd5,  16'h3333, 16'h4444, 16'h0000, 1'b1, 1'b0, 1'b0, 5'b00000, 4'd0,  4'd0,  4'd0,  16'h0000, 16'h0000, 16'h0000, 16'd2};
        vecs[11] = '{1'b0, 5'b10101, 4'd9,  4'd10, 4'd11, 16'h9999, 16'hAAAA, 16'h00FF, 1'b0, 1'b0, 1'b0, 5'b10000, 4'd9,  4'd10, 4'd11, 16'h9999, 16'hAAAA, 16'h00FF, 16'd2};
        vecs[12] = '{1'b0, 5'b11011, 4'd0,  4'd0,  4'd12, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 5'b11010, 4'd0,  4'd0,  4'd12, 16'h0000, 16'h0000, 16'h0000, 16'd2};
        vecs[13] = '{1'b1, 5'b00001, 4'd12, 4'd1,  4'd2,  16'h0C0C, 16'h0101, 16'h0000, 1'b0, 1'b0, 1'b1, 5'b00001, 4'd12, 4'd1,  4'd2,  16'h0C0C, 16'h0101, 16'h0000, 16'd2};
        vecs[14] = '{1'b1, 5'b11011, 4'd0,  4'd0,  4'd13, 16'h0000, 16'h0000, 16'h0050, 1'b0, 1'b0, 1'b1, 5'b11011, 4'd0,  4'd0,  4'd13, 16'h0000, 16'h0000, 16'h0050, 16'd2};
        vecs[15] = '{1'b0, 5'b00001, 4'd13, 4'd0,  4'd1,  16'h0D0D, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 5'b00000, 4'd13, 4'd0,  4'd1,  16'h0D0D, 16'h0000, 16'h0000, 16'd2};

        sat_exp[0] = 2'd1; sat_exp[1] = 2'd2; sat_exp[2] = 2'd3; sat_exp[3] = 2'd3; sat_exp[4] = 2'd3;

        // Second instance idles in reset until its own sequence.
        rst2 = 1'b1;
        {u_if2.id_alu_src, u_if2.id_mr, u_if2.id_mw, u_if2.id_mreg, u_if2.id_enrw} = 5'b11011;
        u_if2.id_valid = 1'b1;
        u_if2.id_rs = 4'd1; u_if2.id_rt = 4'd0; u_if2.id_rd = 4'd1;
        u_if2.id_rs_data = 16'h0001; u_if2.id_rt_data = 16'h0000; u_if2.id_imm = 16'h0002;
        u_if2.flush = 1'b0;

        // Reset with nonzero inputs: a valid load to r15.
        rst = 1'b1;
        rv = '{1'b1, 5'b11011, 4'd1, 4'd2, 4'd15, 16'hFFFF, 16'hEEEE, 16'hDDDD, 1'b0,
               1'b0, 1'b0, 5'b00000, 4'd0, 4'd0, 4'd0, 16'h0000, 16'h0000, 16'h0000, 16'd0};
        drive(rv);
        @(negedge clk);
        chk_comb("rst_c0", 0, 1'b0, 1'b0);
        @(negedge clk);
        chk_comb("rst_c1", 1, 1'b0, 1'b0);
        @(posedge clk); #1;
        chk_regs("rst_regs", 0, rv);
        rst = 1'b0;
        @(negedge clk);
        chk_comb("post_rst", 0, 1'b0, 1'b1);
        @(posedge clk); #1;
        chk("post_rst.ex_rd", 0, 32'(u_if.ex_rd), 32'd15);

        for (int i = 0; i < 16; i++) begin
            drive(vecs[i]);
            @(negedge clk);
            chk_comb("vec", i, vecs[i].e_stall, ~vecs[i].e_stall);
            @(posedge clk); #1;
            chk_regs("vec", i, vecs[i]);
        end

        // Reset asserted while a load-use hazard is present.
        m = '{1'b1, 5'b11011, 4'd0, 4'd0, 4'd7, 16'h0000, 16'h0000, 16'h0070, 1'b0,
              1'b0, 1'b1, 5'b11011, 4'd0, 4'd0, 4'd7, 16'h0000, 16'h0000, 16'h0070, 16'd2};
        drive(m);
        @(negedge clk);
        chk_comb("mid_ld", 0, 1'b0, 1'b1);
        @(posedge clk); #1;
        chk_regs("mid_ld", 0, m);
        m = '{1'b1, 5'b00001, 4'd7, 4'd1, 4'd2, 16'h7777, 16'h1111, 16'h0000, 1'b0,
              1'b0, 1'b0, 5'b00000, 4'd0, 4'd0, 4'd0, 16'h0000, 16'h0000, 16'h0000, 16'd0};
        drive(m);
        rst = 1'b1;
        @(negedge clk);
        chk_comb("mid_rst", 0, 1'b0, 1'b0);
        @(posedge clk); #1;
        chk_regs("mid_rst", 0, m);
        rst = 1'b0;
        m = '{1'b1, 5'b00001, 4'd7, 4'd1, 4'd2, 16'h7777, 16'h1111, 16'h0000, 1'b0,
              1'b0, 1'b1, 5'b00001, 4'd7, 4'd1, 4'd2, 16'h7777, 16'h1111, 16'h0000, 16'd0};
        @(negedge clk);
        chk_comb("after_rst", 0, 1'b0, 1'b1);
        @(posedge clk); #1;
        chk_regs("after_rst", 0, m);

        // Saturation: self-dependent load r1 <- [r1] alternates hazard / proceed.
        rst2 = 1'b0;
        @(negedge clk);
        chk("sat_first.stall", 0, 32'(u_if2.stall), 32'd0);
        @(posedge clk); #1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("sat.stall", k, 32'(u_if2.stall), 32'd1);
            chk("sat.pc_write", k, 32'(u_if2.pc_write), 32'd0);
            @(posedge clk); #1;
            chk("sat.stall_cnt", k, 32'(u_if2.stall_cnt), 32'(sat_exp[k]));
            @(negedge clk);
            chk("sat.clear", k, 32'(u_if2.stall), 32'd0);
            @(posedge clk); #1;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline stage, directly downstream of the decode control unit (4-bit opcode → ALU_src, MR, MW, MReg, EnRW).
- Registers decoded control bits, register operands, destination index and immediate for the EX stage.
- Performs load-use hazard detection and drives PCWrite/IFIDWrite (stall) back to fetch/decode.
- Inserts bubbles on hazard or flush, and keeps a saturating stall-cycle counter for debug.

Parameters:
- DATA_W, 16, operand/immediate width.
- REG_AW, 4, register index width.
- CNT_W, 16, stall counter width.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- id_alu_src  input  1  decoded ALU_src.
- id_mr  input  1  decoded MR (load).
- id_mw  input  1  decoded MW (store).
- id_mreg  input  1  decoded MReg (writeback mux select).
- id_enrw  input  1  decoded EnRW (register write enable).
- id_valid  input  1  decode slot holds a real instruction.
- id_rs  input  REG_AW  source register A index.
- id_rt  input  REG_AW  source register B index.
- id_rd  input  REG_AW  destination index.
- id_rs_data  input  DATA_W  register file read A.
- id_rt_data  input  DATA_W  register file read B.
- id_imm  input  DATA_W  sign-extended immediate.
- flush  input  1  squash instruction entering EX (branch redirect).
- ex_alu_src, ex_mr, ex_mw, ex_mreg, ex_enrw  output  1 each  registered control bits.
- ex_valid  output  1  EX slot holds a real instruction.
- ex_rs, ex_rt, ex_rd  output  REG_AW each  registered indices (feed forwarding unit).
- ex_rs_data, ex_rt_data, ex_imm  output  DATA_W each  registered operands.
- pc_write  output  1  PC update enable.
- ifid_write  output  1  IF/ID register enable.
- stall  output  1  hazard detected this cycle.
- stall_cnt  output  CNT_W  saturating count of hazard bubbles.

Behaviour:
- Reset (rst=1 at posedge): all ex_* registers and ex_valid = 0; stall_cnt = 0. While rst is high, pc_write = ifid_write = 0 and stall = 0.
- rt_used = ~id_alu_src | id_mw.
- hazard = ex_valid & ex_mr & id_valid & ((ex_rd == id_rs) | (rt_used & (ex_rd == id_rt))). It is combinational from the current EX registers and ID inputs.
- stall = hazard & ~flush & ~rst. pc_write = ifid_write = ~stall & ~rst.
- Each posedge (rst=0) loads the ID/EX register. There is no hold state.
  - flush=1 or stall=1: load a bubble. ex_valid, ex_alu_src, ex_mr, ex_mw, ex_mreg, ex_enrw = 0; indices and data = 0.
  - Otherwise: load all id_* fields. ex_valid = id_valid.
  - id_valid=0 with no flush/stall: fields are loaded, but ex_mw and ex_enrw are forced 0 so no side effects occur.
- Latency: one cycle, ID to EX.
- A load-use hazard produces exactly one bubble. The next cycle ex_mr = 0, so the hazard clears and the held instruction proceeds.
- Flush and hazard asserted together: flush wins. A bubble is inserted, stall = 0, pc_write = 1, and stall_cnt is unchanged.
- stall_cnt increments by 1 on each posedge where stall = 1. It saturates at 2^CNT_W − 1 with no wrap.
- Reset asserted mid-stall clears everything. The first cycle after reset has no hazard.

Decomposition:
- Shared package holds:
  - opcode constants (OP_ALU=4'b0000, OP_ST=4'b0001, OP_ADDI=4'b0011, OP_ALU2=4'b0111);
  - the bubble control vector constant;
  - DATA_W/REG_AW defaults.
- One sub-module, hazard_detect: purely combinational hazard/stall/pc_write/ifid_write logic.
- The pipeline register and counter stay in the top module.

Test Plan:
- Reset: hold rst 2 cycles with nonzero inputs → all ex_* = 0, stall_cnt = 0, pc_write = 0 during reset, pc_write = 1 in the first cycle after.
- Pass-through: id_valid=1, ALU op rs=2, rt=3, rd=4, rs_data=16'h1234 → next cycle ex_rd = 4, ex_rs_data = 16'h1234, ex_enrw = 1, stall = 0.
- Load-use: EX holds MR=1, rd=5; ID rs=5 → stall = 1, pc_write = ifid_write = 0, bubble in EX next cycle, stall_cnt = 1. The instruction enters EX the following cycle.
- rt not used: EX load rd=6; ID has alu_src=1, mw=0, rt=6, rs=1 → stall = 0. The same case with mw=1 → stall = 1.
- Flush beats hazard: load-use condition with flush=1 → stall = 0, bubble loaded, stall_cnt unchanged.
- Saturation: CNT_W=2, force 5 consecutive load-use hazards → stall_cnt stops at 3.
